// File: rtl/poly_svf_synth.sv
// Time-multiplexed polyphonic synth: per-voice octave oscillator + 2-pole SVF lowpass, summed per frame.
// Build option: define POLY_SVF_MIX_SATURATE_EN to clamp the frame mix instead of wrapping it.
module poly_svf_synth #(
  parameter int unsigned NUM_VOICES   = 2,
  parameter int unsigned PERIOD_BITS  = 10,
  parameter int unsigned OCT_BITS     = 3,
  parameter int unsigned WAVE_BITS    = 8,
  parameter int unsigned LEAST_SHR    = 3,
  parameter int unsigned DIVIDER_BITS = 7,
  localparam int unsigned VB = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [VB+1:0]               cfg_addr,
  input  logic [7:0]                  cfg_data,
  output logic signed [WAVE_BITS-1:0] sample_out,
  output logic                        sample_valid,
  output logic                        frame_start
);

  localparam int unsigned SLOT_BITS = VB + 2;
  localparam int unsigned LAST_SLOT = 4 * NUM_VOICES - 1;
  localparam int unsigned OCTS      = 2 ** OCT_BITS;
  localparam int unsigned EXTRA     = LEAST_SHR + OCTS - 1;
  localparam int unsigned FW        = WAVE_BITS + EXTRA;
  localparam int unsigned MIX_BITS  = WAVE_BITS + $clog2(NUM_VOICES) + 1;
  localparam int unsigned PB        = PERIOD_BITS - 1;

  localparam logic [PB-1:0]       PERIOD_RST = PB'(56);
  localparam logic [OCT_BITS-1:0] OCT_RST    = OCT_BITS'(3);
  localparam logic [2:0]          CUTOFF_RST = 3'd3;
  localparam logic [2:0]          DAMP_RST   = 3'd4;

  // Per-voice configuration and state
  logic [PB-1:0]          period_r [NUM_VOICES];
  logic [OCT_BITS-1:0]    oct_r    [NUM_VOICES];
  logic [1:0]             mode_r   [NUM_VOICES];
  logic [2:0]             cutoff_r [NUM_VOICES];
  logic [2:0]             damp_r   [NUM_VOICES];
  logic                   en_r     [NUM_VOICES];
  logic [PERIOD_BITS-1:0] cnt_r    [NUM_VOICES];
  logic [WAVE_BITS-1:0]   saw_r    [NUM_VOICES];
  logic signed [FW-1:0]   y_r      [NUM_VOICES];
  logic signed [FW-1:0]   v_r      [NUM_VOICES];

  logic [SLOT_BITS-1:0]       slot;
  logic [DIVIDER_BITS-1:0]    div_r;
  logic [DIVIDER_BITS-1:0]    rise_r;
  logic signed [MIX_BITS-1:0] mix_r;

  logic [VB-1:0]          cur;
  logic [1:0]             phase;
  logic [PB-1:0]          per_c;
  logic [OCT_BITS-1:0]    oct_c;
  logic [1:0]             mode_c;
  logic [2:0]             cutoff_c;
  logic [2:0]             damp_c;
  logic                   en_c;
  logic [PERIOD_BITS-1:0] cnt_c;
  logic [WAVE_BITS-1:0]   saw_c;
  logic signed [FW-1:0]   y_c;
  logic signed [FW-1:0]   v_c;

  assign cur      = slot[SLOT_BITS-1:2];
  assign phase    = slot[1:0];
  assign per_c    = period_r[cur];
  assign oct_c    = oct_r[cur];
  assign mode_c   = mode_r[cur];
  assign cutoff_c = cutoff_r[cur];
  assign damp_c   = damp_r[cur];
  assign en_c     = en_r[cur];
  assign cnt_c    = cnt_r[cur];
  assign saw_c    = saw_r[cur];
  assign y_c      = y_r[cur];
  assign v_c      = v_r[cur];

  // Octave enables: the whole frame sees the edges of the increment made at slot 0
  logic [DIVIDER_BITS-1:0] rise_c;
  logic [OCTS-1:0]         oct_en_c;
  logic                    osc_step_c;

  always_comb begin
    rise_c = rise_r;
    if (slot == '0) begin
      rise_c = (div_r + DIVIDER_BITS'(1)) & ~div_r;
    end
  end

  assign oct_en_c   = {rise_c[OCTS-2:0], 1'b1};
  assign osc_step_c = oct_en_c[oct_c] & en_c;

  // Waveform shaping from the saw phase
  logic [WAVE_BITS-1:0]        wave_c;
  logic signed [WAVE_BITS-1:0] wave_s_c;

  always_comb begin
    wave_c = saw_c;
    case (mode_c)
      2'd0:    wave_c = saw_c;
      2'd1:    wave_c = {WAVE_BITS{saw_c[WAVE_BITS-1]}};
      2'd2:    wave_c = saw_c[WAVE_BITS-1] ? ~(saw_c << 1) : (saw_c << 1);
      default: wave_c = {1'b1, {(WAVE_BITS-1){1'b0}}};
    endcase
  end

  assign wave_s_c = {~wave_c[WAVE_BITS-1], wave_c[WAVE_BITS-2:0]};

  // Shared filter adder: one accumulate per slot, operand picked by phase
  logic signed [FW-1:0] v_shr_c;
  logic signed [FW-1:0] y_shr_c;
  logic signed [FW-1:0] wave_ext_c;
  logic signed [FW-1:0] addend_c;
  logic signed [FW-1:0] base_c;
  logic signed [FW-1:0] sum_c;

  always_comb begin
    v_shr_c    = v_c >>> LEAST_SHR;
    y_shr_c    = y_c >>> LEAST_SHR;
    wave_ext_c = {{EXTRA{wave_s_c[WAVE_BITS-1]}}, wave_s_c};
    addend_c   = '0;
    case (phase)
      2'd0:    addend_c = (~v_shr_c) >>> damp_c;
      2'd1:    addend_c = (wave_ext_c <<< (OCTS - 2)) >>> cutoff_c;
      2'd2:    addend_c = v_shr_c >>> cutoff_c;
      default: addend_c = (~y_shr_c) >>> cutoff_c;
    endcase
    base_c = (phase == 2'd2) ? y_c : v_c;
    sum_c  = base_c + addend_c;
  end

  logic signed [MIX_BITS-1:0] mix_add_c;
  logic signed [MIX_BITS-1:0] mix_fin_c;
  logic [WAVE_BITS-1:0]       sample_c;

  assign mix_add_c = en_c ? MIX_BITS'(y_c >>> EXTRA) : '0;
  assign mix_fin_c = mix_r + mix_add_c;

`ifdef POLY_SVF_MIX_SATURATE_EN
  localparam logic signed [MIX_BITS-1:0] SAT_HI = MIX_BITS'((2 ** (WAVE_BITS - 1)) - 1);
  localparam logic signed [MIX_BITS-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    sample_c = mix_fin_c[WAVE_BITS-1:0];
    if (mix_fin_c > SAT_HI) begin
      sample_c = SAT_HI[WAVE_BITS-1:0];
    end else if (mix_fin_c < SAT_LO) begin
      sample_c = SAT_LO[WAVE_BITS-1:0];
    end
  end
`else
  assign sample_c = mix_fin_c[WAVE_BITS-1:0];
`endif

  logic [VB-1:0] wr_voice_c;
  logic [1:0]    wr_reg_c;
  logic          wr_ok_c;

  assign wr_voice_c = cfg_addr[VB+1:2];
  assign wr_reg_c   = cfg_addr[1:0];
  assign wr_ok_c    = cfg_we && (32'(wr_voice_c) < NUM_VOICES);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot         <= '0;
      div_r        <= '0;
      rise_r       <= '0;
      mix_r        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        period_r[i] <= PERIOD_RST;
        oct_r[i]    <= OCT_RST;
        mode_r[i]   <= 2'd0;
        cutoff_r[i] <= CUTOFF_RST;
        damp_r[i]   <= DAMP_RST;
        en_r[i]     <= 1'b1;
        cnt_r[i]    <= '0;
        saw_r[i]    <= '0;
        y_r[i]      <= '0;
        v_r[i]      <= '0;
      end
    end else begin
      slot         <= (slot == SLOT_BITS'(LAST_SLOT)) ? '0 : slot + SLOT_BITS'(1);
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;

      if (slot == '0) begin
        div_r  <= div_r + DIVIDER_BITS'(1);
        rise_r <= rise_c;
      end

      if (phase == 2'd2) begin
        y_r[cur] <= sum_c;
      end else begin
        v_r[cur] <= sum_c;
      end

      // Disabled voices hold their oscillator but keep filtering
      if (phase == 2'd0 && osc_step_c) begin
        if (cnt_c[PERIOD_BITS-1:WAVE_BITS] == '0) begin
          cnt_r[cur] <= cnt_c + {1'b1, per_c} - PERIOD_BITS'(2 ** WAVE_BITS);
          saw_r[cur] <= saw_c + WAVE_BITS'(1);
        end else begin
          cnt_r[cur] <= cnt_c - PERIOD_BITS'(2 ** WAVE_BITS);
        end
      end

      if (phase == 2'd3) begin
        if (slot == SLOT_BITS'(LAST_SLOT)) begin
          sample_out   <= sample_c;
          sample_valid <= 1'b1;
          frame_start  <= 1'b1;
          mix_r        <= '0;
        end else begin
          mix_r <= mix_fin_c;
        end
      end

      if (wr_ok_c) begin
        case (wr_reg_c)
          2'd0: period_r[wr_voice_c][7:0] <= cfg_data;
          2'd1: begin
            period_r[wr_voice_c][PB-1] <= cfg_data[0];
            oct_r[wr_voice_c]          <= cfg_data[OCT_BITS:1];
            mode_r[wr_voice_c]         <= cfg_data[5:4];
          end
          2'd2: begin
            cutoff_r[wr_voice_c] <= cfg_data[2:0];
            damp_r[wr_voice_c]   <= cfg_data[5:3];
          end
          default: en_r[wr_voice_c] <= cfg_data[0];
        endcase
      end
    end
  end

endmodule
